// File: rtl/goertzel_pkg.sv
// Shared types, defaults and the sample formatting function for the Goertzel front end.
package goertzel_pkg;

   localparam int DEF_IN_W    = 12;
   localparam int DEF_OUT_W   = 61;
   localparam int DEF_FRAC_W  = 19;
   localparam int DEF_BLOCK_N = 205;

   // Working width for formatting; wide enough for any supported IN_W/FRAC_W/gain combination.
   localparam int FMT_W     = 128;
   localparam int TAG_IDX_W = 16;

   typedef struct packed {
      logic                 first;
      logic                 last;
      logic [TAG_IDX_W-1:0] idx;
   } tag_t;

   typedef struct packed {
      logic [FMT_W-1:0] y;
      logic             sat;
   } fmt_t;

   // x must arrive sign-extended to FMT_W; y is clamped into a signed out_w-bit range.
   function automatic fmt_t fmt_sat(input logic signed [FMT_W-1:0] x,
                                    input logic [7:0] gain_sh,
                                    input int frac_w,
                                    input int out_w);
      logic signed [FMT_W-1:0] v;
      logic signed [FMT_W-1:0] maxp;
      logic signed [FMT_W-1:0] maxn;
      fmt_t r;
      v    = x <<< (frac_w + int'(gain_sh));
      maxp = {FMT_W{1'b1}} >> (FMT_W - out_w + 1);
      maxn = ~maxp;
      r.sat = 1'b1;
      if (v > maxp) begin
         r.y = maxp;
      end else if (v < maxn) begin
         r.y = maxn;
      end else begin
         r.y   = v;
         r.sat = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/sample_framer_if.sv
// Sample stream bundle: ADC-side input handshake and tagged output handshake.
interface sample_framer_if
   import goertzel_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int CNT_W = $clog2(DEF_BLOCK_N)
);
   logic [IN_W-1:0]  x;
   logic             in_valid;
   logic             in_ready;
   logic [OUT_W-1:0] y;
   logic             out_valid;
   logic             out_ready;
   logic             out_first;
   logic             out_last;
   logic [CNT_W-1:0] idx;

   modport master (output x, in_valid, out_ready,
                   input  in_ready, y, out_valid, out_first, out_last, idx);
   modport slave  (input  x, in_valid, out_ready,
                   output in_ready, y, out_valid, out_first, out_last, idx);
endinterface

// File: rtl/sample_skid_buf.sv
// Two-entry valid/ready skid buffer with a registered in_ready and an enable gate.
module sample_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);
   logic [W-1:0] skid_data;
   logic         skid_valid;
   logic         accept;
   logic         drain;

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   // in_ready only rises with the skid empty, so an accept always has a free slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b0;
      end else begin
         in_ready <= en & ~(skid_valid | (out_valid & ~drain & accept));
         if (skid_valid) begin
            if (drain) begin
               out_data   <= skid_data;
               skid_valid <= 1'b0;
            end
         end else if (out_valid & ~drain) begin
            if (accept) begin
               skid_data  <= in_data;
               skid_valid <= 1'b1;
            end
         end else begin
            out_valid <= accept;
            if (accept) out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/sample_framer.sv
// ADC sample formatter for the Goertzel core: gain/saturate, block tagging, skid-buffered output.
module sample_framer
   import goertzel_pkg::*;
#(
   parameter int IN_W          = DEF_IN_W,
   parameter int OUT_W         = DEF_OUT_W,
   parameter int FRAC_W        = DEF_FRAC_W,
   parameter int BLOCK_N       = DEF_BLOCK_N,
   parameter int CNT_W         = $clog2(BLOCK_N),
   parameter int OFFSET_BINARY = 0,
   parameter int SH_W          = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            restart,
   input  logic [SH_W-1:0] gain_sh,
   sample_framer_if.slave  bus,
   output logic            ovf
);
   localparam int PW = OUT_W + 2 + CNT_W;

   logic [IN_W-1:0]  s;
   fmt_t             fmt;
   tag_t             tag;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cur;
   logic             accept;
   logic [PW-1:0]    pay_in;
   logic [PW-1:0]    pay_out;
   logic             unused_bits;

   assign accept = bus.in_valid & bus.in_ready;
   assign s      = (OFFSET_BINARY != 0) ? {~bus.x[IN_W-1], bus.x[IN_W-2:0]} : bus.x;
   assign fmt    = fmt_sat({{(FMT_W-IN_W){s[IN_W-1]}}, s}, 8'(gain_sh), FRAC_W, OUT_W);

   // A restart coinciding with an accept makes that very sample index 0.
   assign cur       = restart ? '0 : cnt;
   assign tag.first = (cur == '0);
   assign tag.last  = (cur == CNT_W'(BLOCK_N - 1));
   assign tag.idx   = TAG_IDX_W'(cur);

   assign pay_in      = {fmt.y[OUT_W-1:0], tag.first, tag.last, tag.idx[CNT_W-1:0]};
   assign unused_bits = ^{fmt.y[FMT_W-1:OUT_W], tag.idx[TAG_IDX_W-1:CNT_W]};

   // Saturation on an accept outranks a simultaneous restart clearing ovf.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         if (accept) cnt <= tag.last ? '0 : cur + 1'b1;
         else if (restart) cnt <= '0;
         if (accept & fmt.sat) ovf <= 1'b1;
         else if (restart) ovf <= 1'b0;
      end
   end

   sample_skid_buf #(.W(PW)) skid (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_data  (pay_in),
      .in_valid (bus.in_valid),
      .in_ready (bus.in_ready),
      .out_data (pay_out),
      .out_valid(bus.out_valid),
      .out_ready(bus.out_ready)
   );

   assign {bus.y, bus.out_first, bus.out_last, bus.idx} = pay_out;

endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer: three parameterisations driven in lockstep against a queue-based model.
module tb_sample_framer;

   localparam int OUTW [3] = '{61, 32, 61};
   localparam int BN   [3] = '{205, 4, 205};
   localparam int OBN  [3] = '{0, 0, 1};
   localparam int T4IDX[10] = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0};

   typedef struct {
      logic [11:0] x;
      int          gsh;
      int          ia;
      int          ib;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst, en, restart, in_valid, out_ready;
   logic [2:0]  gain_sh;
   logic [11:0] x;
   logic [2:0]  ovf;

   logic [63:0] yo [3];
   logic        ov [3];
   logic        ir [3];
   logic        fo [3];
   logic        lo [3];
   logic [7:0]  io [3];

   rec_t q[$];
   int   cnt_a, cnt_b, nacc;
   bit   ovf_m [3];
   bit   armed;
   int   nchk, npass, nfail;

   always #5 clk = ~clk;

   sample_framer_if #(.IN_W(12), .OUT_W(61), .CNT_W(8)) ifa ();
   sample_framer_if #(.IN_W(12), .OUT_W(32), .CNT_W(2)) ifb ();
   sample_framer_if #(.IN_W(12), .OUT_W(61), .CNT_W(8)) ifc ();

   assign ifa.x = x;  assign ifa.in_valid = in_valid;  assign ifa.out_ready = out_ready;
   assign ifb.x = x;  assign ifb.in_valid = in_valid;  assign ifb.out_ready = out_ready;
   assign ifc.x = x;  assign ifc.in_valid = in_valid;  assign ifc.out_ready = out_ready;

   sample_framer #(.OUT_W(61)) dut_a (
      .clk(clk), .rst(rst), .en(en), .restart(restart), .gain_sh(gain_sh), .bus(ifa), .ovf(ovf[0]));
   sample_framer #(.OUT_W(32), .BLOCK_N(4)) dut_b (
      .clk(clk), .rst(rst), .en(en), .restart(restart), .gain_sh(gain_sh), .bus(ifb), .ovf(ovf[1]));
   sample_framer #(.OFFSET_BINARY(1)) dut_c (
      .clk(clk), .rst(rst), .en(en), .restart(restart), .gain_sh(gain_sh), .bus(ifc), .ovf(ovf[2]));

   assign yo[0] = 64'(ifa.y);  assign yo[1] = 64'(ifb.y);  assign yo[2] = 64'(ifc.y);
   assign ov[0] = ifa.out_valid;  assign ov[1] = ifb.out_valid;  assign ov[2] = ifc.out_valid;
   assign ir[0] = ifa.in_ready;   assign ir[1] = ifb.in_ready;   assign ir[2] = ifc.in_ready;
   assign fo[0] = ifa.out_first;  assign fo[1] = ifb.out_first;  assign fo[2] = ifc.out_first;
   assign lo[0] = ifa.out_last;   assign lo[1] = ifb.out_last;   assign lo[2] = ifc.out_last;
   assign io[0] = 8'(ifa.idx);    assign io[1] = 8'(ifb.idx);    assign io[2] = 8'(ifc.idx);

   // Reference format: interpret x as a number, scale by 2^(19+gain), clamp to the output range.
   function automatic void ref_fmt(input logic [11:0] xi, input int gsh, input int outw,
                                   input int ob, output logic [63:0] y, output bit sat);
      longint val, v, maxp, maxn;
      if (ob != 0) val = longint'(xi) - 2048;
      else val = (xi >= 12'h800) ? longint'(xi) - 4096 : longint'(xi);
      v    = val * (longint'(1) << (19 + gsh));
      maxp = (longint'(1) << (outw - 1)) - 1;
      maxn = -(longint'(1) << (outw - 1));
      sat  = 1'b0;
      if (v > maxp) begin v = maxp; sat = 1'b1; end
      else if (v < maxn) begin v = maxn; sat = 1'b1; end
      y = 64'(v) & ((64'd1 << outw) - 64'd1);
   endfunction

   task automatic applyStimulus_dummy();
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe handshakes at the negedge, update the model, return just after posedge.
   task automatic applyStimulus();
      rec_t        r;
      logic [63:0] ye;
      bit          sat, acc, drn;
      int          ie;
      @(negedge clk);
      if (armed) begin
         acc = (in_valid === 1'b1) && (ir[0] === 1'b1);
         drn = (ov[0] === 1'b1) && (out_ready === 1'b1);
         for (int d = 0; d < 3; d++) begin
            checkOutput("ovf", 64'(ovf[d]), 64'(ovf_m[d]));
            if (d > 0) checkOutput("out_valid_match", 64'(ov[d]), 64'(ov[0]));
         end
         if (drn) begin
            if (q.size() == 0) checkOutput("spurious_word", 64'(ov[0]), 64'(0));
            else begin
               r = q.pop_front();
               for (int d = 0; d < 3; d++) begin
                  ref_fmt(r.x, r.gsh, OUTW[d], OBN[d], ye, sat);
                  ie = (BN[d] == 4) ? r.ib : r.ia;
                  checkOutput("stream_y", yo[d], ye);
                  checkOutput("stream_idx", 64'(io[d]), 64'(ie));
                  checkOutput("stream_first", 64'(fo[d]), 64'(ie == 0));
                  checkOutput("stream_last", 64'(lo[d]), 64'(ie == BN[d] - 1));
               end
            end
         end
         if (rst) begin
            q.delete();
            cnt_a = 0;
            cnt_b = 0;
            for (int d = 0; d < 3; d++) ovf_m[d] = 1'b0;
         end else if (acc) begin
            r.x   = x;
            r.gsh = int'(gain_sh);
            r.ia  = restart ? 0 : cnt_a;
            r.ib  = restart ? 0 : cnt_b;
            cnt_a = (r.ia + 1) % 205;
            cnt_b = (r.ib + 1) % 4;
            q.push_back(r);
            nacc++;
            for (int d = 0; d < 3; d++) begin
               ref_fmt(r.x, r.gsh, OUTW[d], OBN[d], ye, sat);
               if (sat) ovf_m[d] = 1'b1;
               else if (restart) ovf_m[d] = 1'b0;
            end
         end else if (restart) begin
            cnt_a = 0;
            cnt_b = 0;
            for (int d = 0; d < 3; d++) ovf_m[d] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cycles;
      nchk = 0; npass = 0; nfail = 0; nacc = 0; cnt_a = 0; cnt_b = 0; armed = 1'b0;
      for (int d = 0; d < 3; d++) ovf_m[d] = 1'b0;
      rst = 1'b1; en = 1'b1; restart = 1'b0; gain_sh = 3'd0; x = '0;
      in_valid = 1'b0; out_ready = 1'b1;

      applyStimulus();
      armed = 1'b1;
      applyStimulus();
      for (int d = 0; d < 3; d++) begin
         checkOutput("rst_y", yo[d], 64'd0);
         checkOutput("rst_out_valid", 64'(ov[d]), 64'd0);
         checkOutput("rst_first", 64'(fo[d]), 64'd0);
         checkOutput("rst_last", 64'(lo[d]), 64'd0);
         checkOutput("rst_idx", 64'(io[d]), 64'd0);
         checkOutput("rst_ovf", 64'(ovf[d]), 64'd0);
         checkOutput("rst_in_ready", 64'(ir[d]), 64'd0);
      end
      rst = 1'b0;
      applyStimulus();
      for (int d = 0; d < 3; d++) checkOutput("in_ready_after_rst", 64'(ir[d]), 64'd1);

      // T1: full-scale positive, one-cycle latency
      x = 12'h7FF; in_valid = 1'b1;
      checkOutput("t1_idle_valid", 64'(ov[0]), 64'd0);
      applyStimulus();
      in_valid = 1'b0;
      checkOutput("t1_latency_valid", 64'(ov[0]), 64'd1);
      checkOutput("t1_y", yo[0], 64'h3FF80000);
      checkOutput("t1_ovf", 64'(ovf[0]), 64'd0);
      applyStimulus();

      // T2: most negative sample, signed and offset-binary
      x = 12'h800; in_valid = 1'b1;
      applyStimulus();
      in_valid = 1'b0;
      checkOutput("t2_y_signed", yo[0], 64'h1FFF_FFFF_C000_0000);
      checkOutput("t2_y_ob_mid", yo[2], 64'd0);
      applyStimulus();
      x = 12'h000; in_valid = 1'b1;
      applyStimulus();
      in_valid = 1'b0;
      checkOutput("t2_y_ob_min", yo[2], 64'h1FFF_FFFF_C000_0000);
      applyStimulus();

      // T3: saturation on the 32-bit variant, then restart clears ovf
      gain_sh = 3'd7; x = 12'h7FF; in_valid = 1'b1;
      applyStimulus();
      checkOutput("t3_sat_pos", yo[1], 64'h7FFF_FFFF);
      checkOutput("t3_ovf_set", 64'(ovf[1]), 64'd1);
      x = 12'h800;
      applyStimulus();
      in_valid = 1'b0;
      checkOutput("t3_sat_neg", yo[1], 64'h8000_0000);
      applyStimulus();
      gain_sh = 3'd0; restart = 1'b1; x = 12'h001; in_valid = 1'b1;
      applyStimulus();
      restart = 1'b0; in_valid = 1'b0;
      checkOutput("t3_ovf_cleared", 64'(ovf[1]), 64'd0);
      applyStimulus();

      // T4: block tagging with BLOCK_N=4, restart on the sixth accept
      restart = 1'b1;
      applyStimulus();
      restart = 1'b0;
      for (int i = 0; i < 10; i++) begin
         x = 12'($urandom); in_valid = 1'b1; restart = (i == 5);
         applyStimulus();
         checkOutput("t4_idx", 64'(io[1]), 64'(T4IDX[i]));
         checkOutput("t4_first", 64'(fo[1]), 64'(T4IDX[i] == 0));
         checkOutput("t4_last", 64'(lo[1]), 64'(T4IDX[i] == 3));
      end
      restart = 1'b0; in_valid = 1'b0;
      repeat (2) applyStimulus();

      // T5: downstream stall fills exactly two entries, then drains in order
      in_valid = 1'b1; out_ready = 1'b0;
      repeat (5) begin
         x = 12'($urandom);
         applyStimulus();
      end
      checkOutput("t5_buffered", 64'(q.size()), 64'd2);
      checkOutput("t5_in_ready", 64'(ir[0]), 64'd0);
      out_ready = 1'b1; in_valid = 1'b0;
      repeat (4) applyStimulus();
      checkOutput("t5_drained", 64'(q.size()), 64'd0);

      nacc = 0; cycles = 0;
      while (nacc < 1000 && cycles < 8000) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         x         = 12'($urandom);
         gain_sh   = 3'($urandom);
         restart   = ($urandom_range(49) == 0);
         en        = ($urandom_range(19) != 0);
         applyStimulus();
         cycles++;
      end
      checkOutput("t5_random_completed", 64'(nacc >= 1000), 64'd1);
      restart = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) applyStimulus();
      checkOutput("t5_random_drained", 64'(q.size()), 64'd0);

      // T6: reset with words buffered, then en=0 drain
      gain_sh = 3'd7; x = 12'h7FF; in_valid = 1'b1; out_ready = 1'b0;
      repeat (3) applyStimulus();
      checkOutput("t6_full_valid", 64'(ov[0]), 64'd1);
      checkOutput("t6_ovf_pre", 64'(ovf[1]), 64'd1);
      rst = 1'b1; in_valid = 1'b0;
      applyStimulus();
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         checkOutput("t6_rst_valid", 64'(ov[d]), 64'd0);
         checkOutput("t6_rst_ovf", 64'(ovf[d]), 64'd0);
      end
      out_ready = 1'b1;
      applyStimulus();
      gain_sh = 3'd0; x = 12'($urandom); in_valid = 1'b1;
      applyStimulus();
      in_valid = 1'b0;
      checkOutput("t6_post_rst_idx", 64'(io[0]), 64'd0);
      checkOutput("t6_post_rst_first", 64'(fo[0]), 64'd1);
      applyStimulus();

      out_ready = 1'b0; in_valid = 1'b1;
      repeat (3) applyStimulus();
      en = 1'b0;
      applyStimulus();
      checkOutput("t6_en_low_ready", 64'(ir[0]), 64'd0);
      out_ready = 1'b1;
      repeat (4) begin
         applyStimulus();
         checkOutput("t6_drain_ready", 64'(ir[0]), 64'd0);
      end
      checkOutput("t6_en_low_drained", 64'(q.size()), 64'd0);
      in_valid = 1'b0; en = 1'b1;
      applyStimulus();

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
